// File: rtl/replay_buffer_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : replay_buffer_p
// Description : Link-layer TLP replay buffer. Holds unacknowledged TLPs,
//               purges them on ACK/NAK and streams them out in OUT_W beats on
//               NAK or replay-timer expiry.
//               Optional feature macro: REPLAY_LIMIT_EN (retrain after 3
//               consecutive replays instead of replaying a 4th time).
// Revision    : 1.0 - initial release
// ============================================================================
module replay_buffer_p #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 16,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [DATA_W-1:0]        din,
  input  logic [SEQ_W-1:0]         seq_in,
  output logic                     ready,
  input  logic [1:0]               acknak,
  input  logic [SEQ_W-1:0]         ack_seq,
  input  logic                     tim_out,
  input  logic                     busy_n,
  output logic [OUT_W-1:0]         dout,
  output logic                     dout_vld,
  output logic                     sof,
  output logic                     eof,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     replaying,
  output logic                     retrain
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_beats  = DATA_W / OUT_W;
  localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;

  localparam logic [c_addr_w-1:0] c_ptr_one   = 1;
  localparam logic [c_addr_w:0]   c_cnt_one   = 1;
  localparam logic [c_addr_w:0]   c_full      = (c_addr_w+1)'(DEPTH);
  localparam logic [c_beat_w-1:0] c_beat_one  = 1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PURGE       = 3'd1,
    REPLAY_LOAD = 3'd2,
    REPLAY_SEND = 3'd3,
    REPLAY_NEXT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [DATA_W-1:0]     r_mem_data [DEPTH];
  logic [SEQ_W-1:0]      r_mem_seq  [DEPTH];

  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_count;
  logic [SEQ_W-1:0]      r_ack_seq;
  logic                  r_nak;
  logic [c_addr_w-1:0]   r_cur;
  // Entries still to send in this pass; fixed at load so later writes are excluded
  // and a completely full buffer (wr_ptr == rd_ptr) is still handled.
  logic [c_addr_w:0]     r_left;
  logic [c_beat_w-1:0]   r_beat;
  logic [1:0]            r_replay_num;
  logic [OUT_W-1:0]      r_dout;
  logic                  r_dout_vld;
  logic                  r_sof;
  logic                  r_eof;
  logic                  r_retrain;

  logic                  w_wr;
  logic [SEQ_W-1:0]      w_diff;
  logic                  w_purge_ok;
  logic                  w_purge;
  logic                  w_latch_ack;
  logic                  w_start;
  logic                  w_limit_hit;
  logic                  w_emit;
  logic                  w_adv;
  logic [DATA_W-1:0]     w_word;
  logic [OUT_W-1:0]      w_chunk;

  assign ready      = (r_count != c_full);
  assign w_wr       = we && ready;
  // Entry is covered by the ACK when (ack - seq) mod 2^SEQ_W is in the lower half
  assign w_diff     = r_ack_seq - r_mem_seq[r_rd_ptr];
  assign w_purge_ok = (r_count != '0) && !w_diff[SEQ_W-1];
  assign w_word     = r_mem_data[r_cur] << (r_beat * OUT_W);
  assign w_chunk    = w_word[DATA_W-1 -: OUT_W];

  always_comb begin
    w_next_state = r_state;
    w_purge      = 1'b0;
    w_latch_ack  = 1'b0;
    w_start      = 1'b0;
    w_limit_hit  = 1'b0;
    w_emit       = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (acknak == 2'b01 || acknak == 2'b10) begin
          w_latch_ack  = 1'b1;
          w_next_state = PURGE;
        end else if (tim_out) begin
          w_next_state = REPLAY_LOAD;
        end
      end
      PURGE: begin
        if (w_purge_ok) begin
          w_purge = 1'b1;
        end else begin
          w_next_state = r_nak ? REPLAY_LOAD : IDLE;
        end
      end
      REPLAY_LOAD: begin
        if (r_count == '0) begin
          w_next_state = IDLE;
`ifdef REPLAY_LIMIT_EN
        end else if (r_replay_num == 2'd3) begin
          w_limit_hit  = 1'b1;
          w_next_state = IDLE;
`endif
        end else begin
          w_start      = 1'b1;
          w_next_state = REPLAY_SEND;
        end
      end
      REPLAY_SEND: begin
        if (busy_n) begin
          w_emit = 1'b1;
          if (r_beat == c_last_beat) begin
            w_next_state = REPLAY_NEXT;
          end
        end
      end
      REPLAY_NEXT: begin
        w_adv        = 1'b1;
        w_next_state = (r_left == c_cnt_one) ? IDLE : REPLAY_SEND;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Entry storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem_data[r_wr_ptr] <= din;
      r_mem_seq[r_wr_ptr]  <= seq_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ack_seq    <= '0;
      r_nak        <= 1'b0;
      r_cur        <= '0;
      r_left       <= '0;
      r_beat       <= '0;
      r_replay_num <= 2'd0;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_retrain    <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      r_retrain  <= 1'b0;

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_wr && !w_purge) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_wr && w_purge) begin
        r_count <= r_count - c_cnt_one;
      end

      if (w_latch_ack) begin
        r_ack_seq <= ack_seq;
        r_nak     <= (acknak == 2'b10);
      end

      if (w_purge) begin
        r_rd_ptr     <= r_rd_ptr + c_ptr_one;
        r_replay_num <= 2'd0;
      end

      if (w_start) begin
        r_cur  <= r_rd_ptr;
        r_left <= r_count;
        r_beat <= '0;
        if (r_replay_num != 2'd3) begin
          r_replay_num <= r_replay_num + 2'd1;
        end
      end

      if (w_limit_hit) begin
        r_replay_num <= 2'd0;
        r_retrain    <= 1'b1;
      end

      if (w_emit) begin
        r_dout     <= w_chunk;
        r_dout_vld <= 1'b1;
        r_sof      <= (r_beat == '0);
        r_eof      <= (r_beat == c_last_beat);
        r_beat     <= (r_beat == c_last_beat) ? '0 : r_beat + c_beat_one;
      end else if (r_state != REPLAY_SEND) begin
        r_sof <= 1'b0;
        r_eof <= 1'b0;
      end

      if (w_adv) begin
        r_cur  <= r_cur + c_ptr_one;
        r_left <= r_left - c_cnt_one;
      end
    end
  end

  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign count     = r_count;
  assign replaying = (r_state == REPLAY_LOAD) || (r_state == REPLAY_SEND) ||
                     (r_state == REPLAY_NEXT);
`ifdef REPLAY_LIMIT_EN
  assign retrain   = r_retrain;
`else
  assign retrain   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_replay_buffer_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_replay_buffer_p
// Description : Directed self-checking bench for replay_buffer_p.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_replay_buffer_p;

  localparam int DATA_W = 128;
  localparam int OUT_W  = 16;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [SEQ_W-1:0]  seq_in = '0;
  logic              ready;
  logic [1:0]        acknak = 2'b00;
  logic [SEQ_W-1:0]  ack_seq = '0;
  logic              tim_out = 1'b0;
  logic              busy_n = 1'b1;
  logic [OUT_W-1:0]  dout;
  logic              dout_vld;
  logic              sof;
  logic              eof;
  logic [3:0]        count;
  logic              replaying;
  logic              retrain;

  int checks = 0;
  int errors = 0;
  int n_retrain = 0;
  logic [17:0] cap[$];

  replay_buffer_p #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .din(din), .seq_in(seq_in),
    .ready(ready), .acknak(acknak), .ack_seq(ack_seq), .tim_out(tim_out),
    .busy_n(busy_n), .dout(dout), .dout_vld(dout_vld), .sof(sof), .eof(eof),
    .count(count), .replaying(replaying), .retrain(retrain)
  );

  always #5 clk = ~clk;

  // Beat log as {sof, eof, dout}
  always @(negedge clk) begin
    if (dout_vld) cap.push_back({sof, eof, dout});
    if (retrain) n_retrain++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0; acknak = 2'b00; tim_out = 1'b0; busy_n = 1'b1;
    tick(); tick();
    reset = 1'b0;
    cap.delete();
    n_retrain = 0;
  endtask

  task automatic write(input logic [SEQ_W-1:0] s, input logic [DATA_W-1:0] d);
    we = 1'b1; din = d; seq_in = s;
    tick();
    we = 1'b0;
  endtask

  task automatic send_ack(input logic [1:0] an, input logic [SEQ_W-1:0] s);
    acknak = an; ack_seq = s;
    tick();
    acknak = 2'b00;
  endtask

  task automatic pulse_to();
    tim_out = 1'b1;
    tick();
    tim_out = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic found_dead;
    int   sz;

    // Reset state
    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_sof", sof, 0);
    chk("rst_eof", eof, 0);
    chk("rst_replaying", replaying, 0);
    chk("rst_retrain", retrain, 0);

    // Timeout on an empty buffer: no output, no replay count
    pulse_to();
    wait_n(5);
    chk("empty_to_beats", cap.size(), 0);
    chk("empty_to_rnum", dut.r_replay_num, 0);

    // Three writes
    for (int i = 0; i < 3; i++) write(SEQ_W'(i), {8{16'h1000 + 16'(i)}});
    chk("w3_count", count, 3);
    chk("w3_ready", ready, 1);
    chk("w3_vld", dout_vld, 0);

    // Timeout replay; an entry written during the pass is not sent
    pulse_to();
    write(12'd3, {8{16'h1003}});
    wait_n(40);
    chk("to_beats", cap.size(), 24);
    chk("to_first", cap[0], {2'b10, 16'h1000});
    chk("to_last", cap[23], {2'b01, 16'h1002});
    chk("to_rnum", dut.r_replay_num, 1);
    chk("to_count", count, 4);

    // ACK seq 1 purges seq 0 and 1
    cap.delete();
    send_ack(2'b01, 12'd1);
    wait_n(5);
    chk("ack_count", count, 2);
    chk("ack_rnum", dut.r_replay_num, 0);
    chk("ack_beats", cap.size(), 0);

    // NAK with stall mid-replay
    do_reset();
    write(12'd0, {8{16'h2000}});
    write(12'd1, 128'h400000010000000ffdaff04012345678);
    write(12'd2, {8{16'h2222}});
    acknak = 2'b10; ack_seq = 12'd0;
    tick();
    acknak = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      busy_n = !(k >= 6 && k <= 8);
      tick();
      if (k == 3) chk("nak_pre_vld", dout_vld, 0);
      if (k == 4) begin
        chk("nak_first_vld", dout_vld, 1);
        chk("nak_first_dout", dout, 16'h4000);
        chk("nak_first_sof", sof, 1);
      end
      if (k == 7) begin
        chk("stall_vld", dout_vld, 0);
        chk("stall_dout", dout, 16'h0001);
      end
    end
    busy_n = 1'b1;
    chk("nak_beats", cap.size(), 16);
    chk("nak_b0", cap[0], {2'b10, 16'h4000});
    chk("nak_b3", cap[3], {2'b00, 16'h000f});
    chk("nak_b7", cap[7], {2'b01, 16'h5678});
    chk("nak_b8", cap[8], {2'b10, 16'h2222});
    chk("nak_b15", cap[15], {2'b01, 16'h2222});
    chk("nak_count", count, 2);

    // Full buffer; 9th write dropped and never replayed
    do_reset();
    for (int i = 0; i < 8; i++) write(SEQ_W'(i), {8{16'h3000 + 16'(i)}});
    chk("full_ready", ready, 0);
    chk("full_count", count, 8);
    write(12'd8, {8{16'hDEAD}});
    chk("full_count9", count, 8);
    pulse_to();
    wait_n(80);
    chk("full_beats", cap.size(), 64);
    found_dead = 1'b0;
    foreach (cap[i]) if (cap[i][15:0] == 16'hDEAD) found_dead = 1'b1;
    chk("full_no_9th", found_dead, 0);
    chk("full_b56", cap[56], {2'b10, 16'h3007});

    // Sequence wrap, ACK beats simultaneous timeout
    do_reset();
    write(12'd4094, {8{16'hA000}});
    write(12'd4095, {8{16'hA001}});
    write(12'd0,    {8{16'hA002}});
    acknak = 2'b01; ack_seq = 12'd4095; tim_out = 1'b1;
    tick();
    acknak = 2'b00; tim_out = 1'b0;
    wait_n(8);
    chk("wrap_count", count, 1);
    chk("wrap_prio_beats", cap.size(), 0);
    pulse_to();
    wait_n(15);
    chk("wrap_beats", cap.size(), 8);
    chk("wrap_b0", cap[0], {2'b10, 16'hA002});

    // Repeated timeouts without ACK
    do_reset();
    write(12'd5, {8{16'hB005}});
    repeat (4) begin
      pulse_to();
      wait_n(15);
    end
`ifdef REPLAY_LIMIT_EN
    chk("lim_beats", cap.size(), 24);
    chk("lim_retrain", n_retrain, 1);
    chk("lim_rnum", dut.r_replay_num, 0);
`else
    chk("lim_beats", cap.size(), 32);
    chk("lim_retrain", n_retrain, 0);
    chk("lim_rnum", dut.r_replay_num, 3);
`endif
    chk("lim_replaying", replaying, 0);

    // Reset mid-replay aborts immediately
    cap.delete();
    pulse_to();
    wait_n(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sz = cap.size();
    chk("abort_vld", dout_vld, 0);
    wait_n(10);
    chk("abort_beats", cap.size(), sz);
    chk("abort_replaying", replaying, 0);
    chk("abort_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
